// File: rtl/mpu_load_sender_pkg.sv
// rtl/mpu_load_sender_pkg.sv - shared constants and state type for the MPU load sender
package mpu_load_sender_pkg;

  localparam int MPU_MAX_M = 4;
  localparam int MPU_MAX_N = 4;
  localparam int MPU_FP_W  = 32;

  // Header word field offsets: m in [15:8], n in [7:0]
  localparam int HDR_M_LSB = 8;
  localparam int HDR_N_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SEND,
    DONE
  } mpu_tx_state_t;

endpackage

// File: rtl/mpu_elem_buffer.sv
// rtl/mpu_elem_buffer.sv - element register file, one write port, combinational read port
module mpu_elem_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are deliberately not reset; the host reloads them before use
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mpu_load_sender.sv
// rtl/mpu_load_sender.sv - buffers one matrix and streams header + row-major elements to the loader
module mpu_load_sender
  import mpu_load_sender_pkg::*;
#(
  parameter int DATA_W = MPU_FP_W,
  parameter int MAX_M  = MPU_MAX_M,
  parameter int MAX_N  = MPU_MAX_N,
  localparam int DEPTH  = MAX_M * MAX_N,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int M_W    = $clog2(MAX_M + 1),
  localparam int N_W    = $clog2(MAX_N + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              buf_wr_en,
  input  logic [ADDR_W-1:0] buf_wr_addr,
  input  logic [DATA_W-1:0] buf_wr_data,
  input  logic              start,
  input  logic [M_W-1:0]    m_in,
  input  logic [N_W-1:0]    n_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              tx_valid,
  output logic              tx_hdr,
  output logic              tx_last,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready
);

  mpu_tx_state_t state_q, state_d;
  logic [M_W-1:0] m_q, m_d, row_q, row_d, nxt_row;
  logic [N_W-1:0] n_q, n_d, col_q, col_d, nxt_col;
  logic           nxt_last, dims_ok;
  logic           valid_d, hdr_d, last_d, err_d, busy_d, done_d;
  logic [DATA_W-1:0] data_d, rd_data;
  logic [ADDR_W-1:0] rd_addr;

  // Writes only in IDLE so the matrix being streamed cannot change under the loader
  mpu_elem_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en && (state_q == IDLE)),
    .wr_addr (buf_wr_addr),
    .wr_data (buf_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign dims_ok = (m_in != '0) && (m_in <= M_W'(MAX_M)) &&
                   (n_in != '0) && (n_in <= N_W'(MAX_N));

  // Position of the beat that follows the current one; HEADER is followed by (0,0)
  always_comb begin
    nxt_row = '0;
    nxt_col = '0;
    if (state_q == SEND) begin
      if (col_q == n_q - 1'b1) begin
        nxt_row = row_q + 1'b1;
      end else begin
        nxt_row = row_q;
        nxt_col = col_q + 1'b1;
      end
    end
    nxt_last = (nxt_row == m_q - 1'b1) && (nxt_col == n_q - 1'b1);
    rd_addr  = ADDR_W'(int'(nxt_row) * MAX_N + int'(nxt_col));
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = tx_valid;
    hdr_d   = tx_hdr;
    last_d  = tx_last;
    data_d  = tx_data;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_d = HEADER;
            m_d     = m_in;
            n_d     = n_in;
            valid_d = 1'b1;
            hdr_d   = 1'b1;
            last_d  = 1'b0;
            data_d  = '0;
            data_d[HDR_M_LSB +: M_W] = m_in;
            data_d[HDR_N_LSB +: N_W] = n_in;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HEADER, SEND: begin
        if (tx_ready) begin
          if ((state_q == SEND) && tx_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            state_d = SEND;
            row_d   = nxt_row;
            col_d   = nxt_col;
            hdr_d   = 1'b0;
            last_d  = nxt_last;
            data_d  = rd_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      tx_valid <= 1'b0;
      tx_hdr   <= 1'b0;
      tx_last  <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      row_q    <= row_d;
      col_q    <= col_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= err_d;
      tx_valid <= valid_d;
      tx_hdr   <= hdr_d;
      tx_last  <= last_d;
      tx_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_mpu_load_sender.sv
// tb/tb_mpu_load_sender.sv - self-checking bench for mpu_load_sender
module tb_mpu_load_sender;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        buf_wr_en = 1'b0;
  logic [3:0]  buf_wr_addr = '0;
  logic [31:0] buf_wr_data = '0;
  logic        start = 1'b0;
  logic [2:0]  m_in = '0;
  logic [2:0]  n_in = '0;
  logic        busy, done, error, tx_valid, tx_hdr, tx_last;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;

  typedef struct {
    logic        hdr;
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int m;
    int n;
    int mode;
    bit exp_err;
    bit wr_start;
    int fill;
  } vec_t;

  beat_t       exp_q[$];
  beat_t       held, e;
  logic        stalled = 1'b0;
  logic [31:0] model [16];
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  int          rcyc = 0;
  vec_t        vecs[10];

  mpu_load_sender dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .start       (start),
    .m_in        (m_in),
    .n_in        (n_in),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .tx_valid    (tx_valid),
    .tx_hdr      (tx_hdr),
    .tx_last     (tx_last),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready patterns: 0 = always high, 1 = toggling, 2 = random
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((rcyc % 2) == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard side: pop on every handshake, hold-check on every stall
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", tx_data, held.data);
        chk("stall_flags", 32'({tx_hdr, tx_last}), 32'({held.hdr, held.last}));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", tx_data, e.data);
          chk("beat_flags", 32'({tx_hdr, tx_last}), 32'({e.hdr, e.last}));
        end
        stalled = 1'b0;
      end else if (tx_valid) begin
        stalled = 1'b1;
        held = '{hdr: tx_hdr, last: tx_last, data: tx_data};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    buf_wr_en   = 1'b1;
    buf_wr_addr = 4'(addr);
    buf_wr_data = data;
    model[addr] = data;
    tick();
    buf_wr_en = 1'b0;
  endtask

  task automatic fill(input int kind);
    logic [31:0] v;
    if (kind == 0) return;
    for (int i = 0; i < 16; i++) begin
      v = 32'd0;
      case (kind)
        1: case (i)
             0: v = 32'h3F800000;
             1: v = 32'h40000000;
             4: v = 32'h40400000;
             5: v = 32'h40800000;
             default: v = 32'd0;
           endcase
        2: v = 32'(i);
        3: v = ((i / 4) == (i % 4)) ? 32'h3F800000 : 32'd0;
        default: v = $urandom;
      endcase
      wr(i, v);
    end
  endtask

  task automatic push_expected(input int m, input int n);
    exp_q.push_back('{hdr: 1'b1, last: 1'b0, data: (32'(m) << 8) | 32'(n)});
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        exp_q.push_back('{hdr: 1'b0, last: (r == m - 1) && (c == n - 1), data: model[r * 4 + c]});
  endtask

  task automatic wait_done(input int cyc_in, output int cyc_out);
    int cyc = cyc_in;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    cyc_out = cyc;
  endtask

  task automatic run_xfer(input int m, input int n, input int mode, input bit exp_err, input bit wr_start);
    int cyc;
    ready_mode = mode;
    if (wr_start) begin
      buf_wr_en   = 1'b1;
      buf_wr_addr = 4'd0;
      buf_wr_data = 32'h12345678;
      model[0]    = 32'h12345678;
    end
    if (!exp_err) push_expected(m, n);
    start = 1'b1;
    m_in  = 3'(m);
    n_in  = 3'(n);
    tick();
    start     = 1'b0;
    buf_wr_en = 1'b0;
    if (exp_err) begin
      chk("err_pulse", 32'(error), 32'd1);
      chk("err_busy", 32'({busy, tx_valid}), 32'd0);
      tick();
      chk("err_clear", 32'({error, busy, tx_valid}), 32'd0);
      return;
    end
    chk("start_hdr", 32'({busy, tx_valid, tx_hdr, error}), 32'b1110);
    wait_done(1, cyc);
    if (mode == 0) chk("done_latency", 32'(cyc), 32'(m * n + 2));
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk("after_done", 32'({done, busy, tx_valid}), 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{m: 2, n: 2, mode: 0, exp_err: 0, wr_start: 0, fill: 1};
    vecs[1] = '{m: 4, n: 4, mode: 1, exp_err: 0, wr_start: 0, fill: 3};
    vecs[2] = '{m: 2, n: 3, mode: 0, exp_err: 0, wr_start: 0, fill: 2};
    vecs[3] = '{m: 0, n: 2, mode: 0, exp_err: 1, wr_start: 0, fill: 0};
    vecs[4] = '{m: 2, n: 5, mode: 0, exp_err: 1, wr_start: 0, fill: 0};
    vecs[5] = '{m: 5, n: 1, mode: 0, exp_err: 1, wr_start: 0, fill: 0};
    vecs[6] = '{m: 1, n: 1, mode: 0, exp_err: 0, wr_start: 1, fill: 0};
    vecs[7] = '{m: 3, n: 4, mode: 2, exp_err: 0, wr_start: 0, fill: 4};
    vecs[8] = '{m: 4, n: 1, mode: 0, exp_err: 0, wr_start: 0, fill: 0};
    vecs[9] = '{m: 1, n: 4, mode: 1, exp_err: 0, wr_start: 0, fill: 0};

    tick();
    tick();
    chk("reset_outputs", 32'({busy, done, error, tx_valid, tx_hdr, tx_last}), 32'd0);
    chk("reset_data", tx_data, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_outputs", 32'({busy, done, error, tx_valid}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      fill(vecs[i].fill);
      run_xfer(vecs[i].m, vecs[i].n, vecs[i].mode, vecs[i].exp_err, vecs[i].wr_start);
    end

    // Buffer write and second start while streaming must both be ignored
    fill(1);
    ready_mode = 0;
    push_expected(2, 2);
    start = 1'b1;
    m_in  = 3'd2;
    n_in  = 3'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    buf_wr_en   = 1'b1;
    buf_wr_addr = 4'd4;
    buf_wr_data = 32'hDEADBEEF;
    start       = 1'b1;
    m_in        = 3'd1;
    n_in        = 3'd0;
    tick();
    buf_wr_en = 1'b0;
    start     = 1'b0;
    chk("busy_start_ignored", 32'({error, busy}), 32'b01);
    wait_done(0, cyc);
    chk("busy_beats_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk("busy_after_done", 32'({busy, tx_valid}), 32'd0);
    run_xfer(2, 2, 0, 0, 0);

    // Asynchronous reset in the middle of SEND
    ready_mode = 0;
    push_expected(4, 4);
    start = 1'b1;
    m_in  = 3'd4;
    n_in  = 3'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({busy, done, error, tx_valid, tx_hdr, tx_last}), 32'd0);
    chk("midreset_data", tx_data, 32'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'({busy, tx_valid}), 32'd0);
    run_xfer(1, 1, 0, 0, 0);
    run_xfer(3, 2, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
